// File: rtl/mips_multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl_pkg
// Brief    : Shared encodings for the multi-cycle MIPS main controller:
//            state encodings, opcode constants, ALU-op codes and mux selects.
//            The ALU control unit uses the same ALUOP_* codes.
// Revision : 1.0 - initial release
// ============================================================================
package mips_multicycle_ctrl_pkg;

  // Controller states. IDLE is entered only from reset. Encodings 14 and 15
  // are unused and recover to FETCH.
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_RWB     = 4'd8,
    S_BEQ     = 4'd9,
    S_IEXEC   = 4'd10,
    S_IWB     = 4'd11,
    S_JUMP    = 4'd12,
    S_ILLEGAL = 4'd13
  } state_t;

  // Opcode field values (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Codes sent to the ALU control unit
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  // ALU B-operand selects
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // State following DECODE for a given opcode
  function automatic state_t decode_target(input logic [5:0] opc);
    state_t nxt;
    case (opc)
      OP_LW, OP_SW:     nxt = S_MEMADR;
      OP_RTYPE:         nxt = S_EXEC;
      OP_BEQ:           nxt = S_BEQ;
      OP_ADDI, OP_ANDI: nxt = S_IEXEC;
      OP_J:             nxt = S_JUMP;
      default:          nxt = S_ILLEGAL;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_ctrl_outdec.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_outdec
// Brief    : Combinational output decoder for the multi-cycle MIPS controller.
//            Maps (state, latched opcode, effective mem_ready) to datapath
//            control signals. mem_ready only gates the FETCH loads and the
//            completion pulse of a store.
// Revision : 1.0 - initial release
// ============================================================================
module mips_ctrl_outdec
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int OPC_W = 6
) (
  input  state_t           state,
  input  logic [OPC_W-1:0] op_q,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             zero_ext,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             instr_done,
  output logic             illegal_op
);

  logic w_is_andi;
  assign w_is_andi = (op_q == OP_ANDI);

  // Per-state control decode; every output defaults low so IDLE and unused
  // encodings drive nothing.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    zero_ext      = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        // IR and PC load only on the cycle the instruction word arrives
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMMSH;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_REG;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = w_is_andi ? ALUOP_AND : ALUOP_ADD;
        zero_ext  = w_is_andi;
      end
      S_IWB: begin
        reg_write  = 1'b1;
        zero_ext   = w_is_andi;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      S_ILLEGAL: begin
        illegal_op = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Brief    : Main control FSM of the multi-cycle MIPS datapath. Holds the
//            state register, the opcode latched in DECODE and the next-state
//            logic; output decode lives in mips_ctrl_outdec.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int OPC_W       = 6,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             zero_ext,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [3:0]       state_o
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [OPC_W-1:0] r_op;
  logic             w_ready;

  // With waits disabled the memory is assumed to answer every cycle
  assign w_ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  // State register and opcode latch; reset is asynchronous so the outputs
  // collapse to the IDLE decode the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_DECODE) begin
        r_op <= opcode;
      end
    end
  end

  // Next-state sequencing; memory states hold until the access completes
  always_comb begin
    w_state_nxt = S_FETCH;
    case (r_state)
      S_IDLE:    w_state_nxt = S_FETCH;
      S_FETCH:   w_state_nxt = w_ready ? S_DECODE : S_FETCH;
      S_DECODE:  w_state_nxt = decode_target(opcode);
      S_MEMADR:  w_state_nxt = (r_op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_state_nxt = w_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   w_state_nxt = w_ready ? S_FETCH : S_MEMWR;
      S_EXEC:    w_state_nxt = S_RWB;
      S_IEXEC:   w_state_nxt = S_IWB;
      default:   w_state_nxt = S_FETCH;
    endcase
  end

  assign state_o = r_state;

  mips_ctrl_outdec #(
    .OPC_W (OPC_W)
  ) u_outdec (
    .state         (r_state),
    .op_q          (r_op),
    .mem_ready     (w_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .zero_ext      (zero_ext),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op)
  );

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_ctrl
// Brief    : Self-checking bench for mips_multicycle_ctrl. Each scenario
//            queues the expected per-cycle control word, then replays the
//            queue against the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;
  import mips_multicycle_ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       zero_ext;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  typedef struct {
    logic [5:0] opc;
    logic       rdy;
    ctrl_t      exp;
  } step_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] opcode;
  logic mem_ready;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic reg_dst, mem_to_reg, reg_write, zero_ext, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic instr_done, illegal_op;
  logic [3:0] state_o;

  ctrl_t obs;
  step_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.OPC_W(6), .MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .zero_ext(zero_ext), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .instr_done(instr_done),
    .illegal_op(illegal_op), .state_o(state_o)
  );

  assign obs = {state_o, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                ir_write, reg_dst, mem_to_reg, reg_write, zero_ext, alu_src_a,
                alu_src_b, alu_op, pc_source, instr_done, illegal_op};

  // ---- expected control words, one per state ----
  function automatic ctrl_t e_idle();
    ctrl_t c = '0; c.state = S_IDLE; return c;
  endfunction
  function automatic ctrl_t e_fetch(input logic rdy);
    ctrl_t c = '0; c.state = S_FETCH; c.mem_read = 1'b1; c.alu_src_b = 2'b01;
    c.ir_write = rdy; c.pc_write = rdy; return c;
  endfunction
  function automatic ctrl_t e_decode();
    ctrl_t c = '0; c.state = S_DECODE; c.alu_src_b = 2'b11; return c;
  endfunction
  function automatic ctrl_t e_memadr();
    ctrl_t c = '0; c.state = S_MEMADR; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; return c;
  endfunction
  function automatic ctrl_t e_memrd();
    ctrl_t c = '0; c.state = S_MEMRD; c.mem_read = 1'b1; c.i_or_d = 1'b1; return c;
  endfunction
  function automatic ctrl_t e_memwb();
    ctrl_t c = '0; c.state = S_MEMWB; c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
    c.instr_done = 1'b1; return c;
  endfunction
  function automatic ctrl_t e_memwr(input logic rdy);
    ctrl_t c = '0; c.state = S_MEMWR; c.mem_write = 1'b1; c.i_or_d = 1'b1;
    c.instr_done = rdy; return c;
  endfunction
  function automatic ctrl_t e_exec();
    ctrl_t c = '0; c.state = S_EXEC; c.alu_src_a = 1'b1; c.alu_op = 2'b10; return c;
  endfunction
  function automatic ctrl_t e_rwb();
    ctrl_t c = '0; c.state = S_RWB; c.reg_write = 1'b1; c.reg_dst = 1'b1;
    c.instr_done = 1'b1; return c;
  endfunction
  function automatic ctrl_t e_beq();
    ctrl_t c = '0; c.state = S_BEQ; c.alu_src_a = 1'b1; c.alu_op = 2'b01;
    c.pc_write_cond = 1'b1; c.pc_source = 2'b01; c.instr_done = 1'b1; return c;
  endfunction
  function automatic ctrl_t e_iexec(input logic andi);
    ctrl_t c = '0; c.state = S_IEXEC; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
    c.alu_op = andi ? 2'b11 : 2'b00; c.zero_ext = andi; return c;
  endfunction
  function automatic ctrl_t e_iwb(input logic andi);
    ctrl_t c = '0; c.state = S_IWB; c.reg_write = 1'b1; c.zero_ext = andi;
    c.instr_done = 1'b1; return c;
  endfunction
  function automatic ctrl_t e_jump();
    ctrl_t c = '0; c.state = S_JUMP; c.pc_write = 1'b1; c.pc_source = 2'b10;
    c.instr_done = 1'b1; return c;
  endfunction
  function automatic ctrl_t e_illegal();
    ctrl_t c = '0; c.state = S_ILLEGAL; c.illegal_op = 1'b1; return c;
  endfunction

  task automatic push(input logic [5:0] opc, input logic rdy, input ctrl_t exp);
    step_t s;
    s.opc = opc; s.rdy = rdy; s.exp = exp;
    sb.push_back(s);
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    rst_n = 1'b0; opcode = 6'd0; mem_ready = 1'b1;
    #3;
    checks++;
    if (obs !== e_idle()) begin
      errors++; $display("FAIL reset_initial: got %h want %h", obs, e_idle());
    end
    @(negedge clk);
    checks++;
    if (obs !== e_idle()) begin
      errors++; $display("FAIL reset_held: got %h want %h", obs, e_idle());
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== e_idle()) begin
      errors++; $display("FAIL reset_release_idle: got %h want %h", obs, e_idle());
    end
  endtask

  task automatic test_lw_fetch_wait();
    step_t s;
    push(OP_LW, 1'b0, e_fetch(1'b0));
    push(OP_LW, 1'b1, e_fetch(1'b1));
    push(OP_LW, 1'b1, e_decode());
    push(OP_LW, 1'b1, e_memadr());
    push(OP_LW, 1'b1, e_memrd());
    push(OP_LW, 1'b1, e_memwb());
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk); opcode = s.opc; mem_ready = s.rdy; #1;
      checks++;
      if (obs !== s.exp) begin
        errors++; $display("FAIL lw: got %h want %h", obs, s.exp);
      end
    end
  endtask

  task automatic test_sw_wait();
    step_t s;
    push(OP_SW, 1'b1, e_fetch(1'b1));
    push(OP_SW, 1'b1, e_decode());
    push(OP_SW, 1'b1, e_memadr());
    push(OP_SW, 1'b0, e_memwr(1'b0));
    push(OP_SW, 1'b0, e_memwr(1'b0));
    push(OP_SW, 1'b1, e_memwr(1'b1));
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk); opcode = s.opc; mem_ready = s.rdy; #1;
      checks++;
      if (obs !== s.exp) begin
        errors++; $display("FAIL sw_wait: got %h want %h", obs, s.exp);
      end
    end
  endtask

  task automatic test_rtype_beq();
    step_t s;
    push(OP_RTYPE, 1'b1, e_fetch(1'b1));
    push(OP_RTYPE, 1'b1, e_decode());
    push(OP_RTYPE, 1'b1, e_exec());
    push(OP_RTYPE, 1'b1, e_rwb());
    push(OP_BEQ, 1'b1, e_fetch(1'b1));
    push(OP_BEQ, 1'b1, e_decode());
    push(OP_BEQ, 1'b1, e_beq());
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk); opcode = s.opc; mem_ready = s.rdy; #1;
      checks++;
      if (obs !== s.exp) begin
        errors++; $display("FAIL rtype_beq: got %h want %h", obs, s.exp);
      end
    end
  endtask

  task automatic test_imm();
    step_t s;
    push(OP_ANDI, 1'b1, e_fetch(1'b1));
    push(OP_ANDI, 1'b1, e_decode());
    push(OP_ANDI, 1'b1, e_iexec(1'b1));
    push(OP_ANDI, 1'b1, e_iwb(1'b1));
    push(OP_ADDI, 1'b1, e_fetch(1'b1));
    push(OP_ADDI, 1'b1, e_decode());
    push(OP_ADDI, 1'b1, e_iexec(1'b0));
    push(OP_ADDI, 1'b1, e_iwb(1'b0));
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk); opcode = s.opc; mem_ready = s.rdy; #1;
      checks++;
      if (obs !== s.exp) begin
        errors++; $display("FAIL imm: got %h want %h", obs, s.exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t s;
    // illegal, then jump, then an lw whose memory read waits one cycle
    push(6'b111111, 1'b1, e_fetch(1'b1));
    push(6'b111111, 1'b1, e_decode());
    push(6'b111111, 1'b1, e_illegal());
    push(OP_J, 1'b1, e_fetch(1'b1));
    push(OP_J, 1'b1, e_decode());
    push(OP_J, 1'b1, e_jump());
    push(OP_LW, 1'b1, e_fetch(1'b1));
    push(OP_LW, 1'b1, e_decode());
    push(OP_LW, 1'b1, e_memadr());
    push(OP_LW, 1'b0, e_memrd());
    push(OP_LW, 1'b1, e_memrd());
    push(OP_LW, 1'b1, e_memwb());
    push(OP_J, 1'b1, e_fetch(1'b1));
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk); opcode = s.opc; mem_ready = s.rdy; #1;
      checks++;
      if (obs !== s.exp) begin
        errors++; $display("FAIL back_to_back: got %h want %h", obs, s.exp);
      end
    end
  endtask

  task automatic test_reset_mid_memwr();
    step_t s;
    push(OP_J, 1'b1, e_decode());
    push(OP_J, 1'b1, e_jump());
    push(OP_SW, 1'b1, e_fetch(1'b1));
    push(OP_SW, 1'b1, e_decode());
    push(OP_SW, 1'b1, e_memadr());
    push(OP_SW, 1'b0, e_memwr(1'b0));
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk); opcode = s.opc; mem_ready = s.rdy; #1;
      checks++;
      if (obs !== s.exp) begin
        errors++; $display("FAIL rst_pre: got %h want %h", obs, s.exp);
      end
    end
    // assert reset between clock edges while the store is waiting
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== e_idle()) begin
      errors++; $display("FAIL rst_async: got %h want %h", obs, e_idle());
    end
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1; opcode = OP_RTYPE;
    #1;
    checks++;
    if (obs !== e_idle()) begin
      errors++; $display("FAIL rst_release: got %h want %h", obs, e_idle());
    end
    push(OP_RTYPE, 1'b1, e_fetch(1'b1));
    push(OP_RTYPE, 1'b1, e_decode());
    push(OP_RTYPE, 1'b1, e_exec());
    push(OP_RTYPE, 1'b1, e_rwb());
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk); opcode = s.opc; mem_ready = s.rdy; #1;
      checks++;
      if (obs !== s.exp) begin
        errors++; $display("FAIL rst_post: got %h want %h", obs, s.exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw_fetch_wait();
    test_sw_wait();
    test_rtype_beq();
    test_imm();
    test_back_to_back();
    test_reset_mid_memwr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
